instr_mem_ctrl: RTL and testbench
=================================

# instr_mem_ctrl

Parametrised, loadable instruction memory for the CPU fetch stage, replacing the fixed combinational program ROM. A program is streamed in word-by-word through a load port after reset. Fetch requests are then served through a valid/ready request/response handshake with one-cycle read latency. Fetch requests that are misaligned or out of range are flagged as errors and return a NOP instead of undefined data.

## Interface
- `DATA_W`, 32, instruction width in bits
- `DEPTH`, 64, memory depth in words (power of two, ≥ 4)
- `PC_W`, 32, byte-address width of the fetch PC
- `clk  in  1`  single clock; all logic on rising edge
- `rst  in  1`  asynchronous, active-high reset
- `load_valid  in  1`  load word present
- `load_data  in  DATA_W`  word to write at the current load pointer
- `load_last  in  1`  qualifies `load_valid`; marks the final word of the program
- `load_restart  in  1`  single-cycle pulse; returns the block to LOAD from RUN
- `loaded  out  1`  high while in RUN
- `load_count  out  $clog2(DEPTH)+1`  number of words written since entering LOAD
- `req_valid  in  1`  fetch request
- `req_pc  in  PC_W`  byte address
- `req_ready  out  1`  request accepted when `req_valid && req_ready`
- `resp_valid  out  1`  response present
- `resp_instr  out  DATA_W`  fetched word; `NOP` (all zeros) on error
- `resp_err  out  1`  misaligned (`req_pc[1:0] != 0`) or out of range (`req_pc >> 2 >= DEPTH`)
- `resp_ready  in  1`  consumer accepts the response

## Operation
- FSM states are LOAD and RUN. Reset enters LOAD.
- **LOAD**
  - Each `load_valid` writes `mem[load_ptr]` and increments `load_ptr` and `load_count`.
  - A write with `load_last = 1`, or a write with `load_ptr == DEPTH-1`, moves the FSM to RUN on the next edge.
  - `req_ready` is 0. Fetch inputs are ignored.
- **RUN**
  - `load_valid` is ignored.
  - `req_ready = !resp_valid || resp_ready`.
  - An accepted request with a valid address reads `mem[req_pc >> 2]` into the response register.
  - An accepted request with an error address loads `resp_instr = 0` and `resp_err = 1`. Memory is not read.
  - `resp_valid` is set by an accepted request. It clears on `resp_ready` when no new request is accepted in the same cycle.
  - A handshake in the same cycle as a response drain gives back-to-back throughput of 1 word per cycle.
- **`load_restart` in RUN**
  - The FSM moves to LOAD on the next edge. `load_ptr` and `load_count` go to 0.
  - `resp_valid` is cleared and any pending response is discarded.
  - Restart has priority over a request accepted in the same cycle: that request is dropped and no response is produced.
- `load_restart` in LOAD has no effect.
- Memory contents are not reset. Words beyond the loaded length are undefined but still return with `resp_err = 0`.

## Timing
- Reset values:
  - `loaded` = 0, `load_count` = 0, `req_ready` = 0
  - `resp_valid` = 0, `resp_instr` = 0, `resp_err` = 0
  - state = LOAD, `load_ptr` = 0
- Asserting `rst` mid-load or mid-fetch aborts the operation immediately. Written words remain in memory but `load_count` restarts from 0.
- Load writes take effect at the edge where `load_valid` is sampled.
- `loaded` rises 1 cycle after the final write, and `req_ready` may rise in that same cycle.
- Fetch latency is 1 cycle: a handshake at edge N gives `resp_valid` with data valid after edge N.
- While `resp_valid && !resp_ready`, `resp_instr` and `resp_err` hold stable and `req_ready` = 0.
- `req_ready` is combinational from `resp_valid`, `resp_ready` and state. There is no combinational path from `req_valid`/`req_pc` to any output.

## Structure
- Package `instr_mem_pkg` holds:
  - state enum `{ST_LOAD, ST_RUN}`
  - `NOP` constant (`32'h0000_0000`)
  - the error-decode helper function `pc_err(pc, depth)`
- Sub-module `instr_mem_ram`: single-port synchronous RAM (`DATA_W` × `DEPTH`) with write enable and registered read. A single port is sufficient because writes happen only in LOAD and reads only in RUN.
- The top level contains the FSM, load pointer and counter, address decode and error check, and the response register with its handshake.

## Test plan
1. Load `0x20080020`, `0x20090027`, `0x01098024` with `load_last` on the third word -> `loaded` = 1 one cycle later and `load_count` = 3. Fetch PCs `0x0`, `0x4`, `0x8` back-to-back with `resp_ready` = 1 -> the three words are returned on consecutive cycles with `resp_err` = 0.
2. In RUN, fetch `req_pc = 0x102` and then `0x100` (`DEPTH` = 64) -> both return `resp_err` = 1 and `resp_instr` = `0x00000000`.
3. Hold `resp_ready` low for 3 cycles after a fetch of `0x4` -> `resp_instr` = `0x20090027` stays stable and `req_ready` = 0 throughout. The response is accepted on the first `resp_ready` cycle.
4. Load 64 words without `load_last` -> the FSM auto-transitions to RUN after word 63 and `load_count` = 64. Fetch `0xFC` -> returns word 63.
5. `load_restart` in the same cycle as an accepted fetch of `0x0` -> no response is produced and the block returns to LOAD with `load_count` = 0. Reloading `0xDEADBEEF` and fetching `0x0` -> returns `0xDEADBEEF`.
6. Assert `rst` asynchronously after 2 load writes -> all outputs take their reset values before the next edge. A fresh load then starts at word 0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types, constants and the fetch-address error decode for the loadable
// instruction memory.
package instr_mem_pkg;

   typedef enum logic {ST_LOAD, ST_RUN} state_e;

   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam int          PC_MAX_W = 64;

   // PCs are zero-extended to PC_MAX_W so one helper serves any PC_W up to 64.
   function automatic logic pc_err(input logic [PC_MAX_W-1:0] pc, input int unsigned depth);
      return (pc[1:0] != 2'b00) || ((pc >> 2) >= PC_MAX_W'(depth));
   endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Load port plus fetch request/response handshake of the instruction memory.
interface instr_mem_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int PC_W   = 32
);
   logic                     load_valid;
   logic [DATA_W-1:0]        load_data;
   logic                     load_last;
   logic                     load_restart;
   logic                     loaded;
   logic [$clog2(DEPTH):0]   load_count;
   logic                     req_valid;
   logic [PC_W-1:0]          req_pc;
   logic                     req_ready;
   logic                     resp_valid;
   logic [DATA_W-1:0]        resp_instr;
   logic                     resp_err;
   logic                     resp_ready;

   modport slave (
      input  load_valid, load_data, load_last, load_restart,
      input  req_valid, req_pc, resp_ready,
      output loaded, load_count, req_ready, resp_valid, resp_instr, resp_err
   );

   modport master (
      output load_valid, load_data, load_last, load_restart,
      output req_valid, req_pc, resp_ready,
      input  loaded, load_count, req_ready, resp_valid, resp_instr, resp_err
   );
endinterface

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM with write enable and a registered, enabled read
// port; the read register holds its value while re is low.
module instr_mem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: LOAD streams a program in, RUN serves fetches
// with one-cycle latency and flags misaligned/out-of-range PCs.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int PC_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   instr_mem_ctrl_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;

   logic [AW-1:0]     load_ptr;
   logic              req_ready;
   logic              req_bad;
   logic              ram_we;
   logic              ram_re;
   logic [AW-1:0]     ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   // The pointer is the low bits of the counter; the counter only reaches
   // DEPTH on the write that also leaves LOAD.
   assign load_ptr = count_q[AW-1:0];
   assign req_bad  = pc_err(PC_MAX_W'(bus.req_pc), DEPTH);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      ram_addr     = load_ptr;
      req_ready    = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (bus.load_valid) begin
               ram_we  = 1'b1;
               count_d = count_q + CW'(1);
               if (bus.load_last || (load_ptr == AW'(DEPTH - 1))) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            req_ready = !resp_valid_q || bus.resp_ready;
            ram_addr  = bus.req_pc[AW+1:2];
            // Restart wins over a same-cycle handshake: the request is dropped.
            if (bus.load_restart) begin
               state_d      = ST_LOAD;
               count_d      = '0;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
            end else if (bus.req_valid && req_ready) begin
               resp_valid_d = 1'b1;
               resp_err_d   = req_bad;
               ram_re       = !req_bad;
            end else if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         count_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   instr_mem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .re     (ram_re),
      .addr   (ram_addr),
      .wdata  (bus.load_data),
      .rdata  (ram_rdata)
   );

   // The RAM output register has no reset, so gate it to NOP unless a good
   // response is being presented.
   assign bus.resp_instr = (resp_valid_q && !resp_err_q) ? ram_rdata : DATA_W'(NOP);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.req_ready  = req_ready;
   assign bus.loaded     = (state_q == ST_RUN);
   assign bus.load_count = count_q;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: load, fetch, error, stall, full load,
// restart and asynchronous reset scenarios.
module tb_instr_mem_ctrl;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   instr_mem_ctrl_if #(.DATA_W(32), .DEPTH(64), .PC_W(32)) bus ();

   instr_mem_ctrl #(.DATA_W(32), .DEPTH(64), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish within 200000");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_valid   = 1'b0;
      bus.load_data    = '0;
      bus.load_last    = 1'b0;
      bus.load_restart = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_pc       = '0;
      bus.resp_ready   = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL reset_loaded: got %b want 0", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd0) begin miscompares++; $display("FAIL reset_load_count: got %0d want 0", bus.load_count); end
      vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
      vectors++; if (bus.resp_instr !== 32'h0) begin miscompares++; $display("FAIL reset_resp_instr: got %h want 00000000", bus.resp_instr); end
      vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
      rst = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_load_fetch();
      logic [31:0] prog [3];
      prog[0] = 32'h2008_0020;
      prog[1] = 32'h2009_0027;
      prog[2] = 32'h0109_8024;
      for (int i = 0; i < 3; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = prog[i];
         bus.load_last  = (i == 2);
         #1;
         vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL load_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
         vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL load_loaded_early[%0d]: got %b want 0", i, bus.loaded); end
         step();
         $display("load word %0d = %h count=%0d", i, prog[i], bus.load_count);
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      vectors++; if (bus.loaded !== 1'b1) begin miscompares++; $display("FAIL load_loaded: got %b want 1", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd3) begin miscompares++; $display("FAIL load_count3: got %0d want 3", bus.load_count); end
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         bus.req_pc    = 32'(i * 4);
         #1;
         vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_req_ready[%0d]: got %b want 1", i, bus.req_ready); end
         step();
         $display("fetch pc=%h instr=%h err=%b", 32'(i * 4), bus.resp_instr, bus.resp_err);
         vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.resp_valid); end
         vectors++; if (bus.resp_instr !== prog[i]) begin miscompares++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, bus.resp_instr, prog[i]); end
         vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL b2b_err[%0d]: got %b want 0", i, bus.resp_err); end
      end
      bus.req_valid = 1'b0;
      step();
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", bus.resp_valid); end
   endtask

   task automatic test_errors();
      logic [31:0] pcs [2];
      pcs[0] = 32'h0000_0102;
      pcs[1] = 32'h0000_0100;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.req_valid = 1'b1;
         bus.req_pc    = pcs[i];
         step();
         $display("fetch pc=%h instr=%h err=%b", pcs[i], bus.resp_instr, bus.resp_err);
         vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL err_valid[%h]: got %b want 1", pcs[i], bus.resp_valid); end
         vectors++; if (bus.resp_err !== 1'b1) begin miscompares++; $display("FAIL err_flag[%h]: got %b want 1", pcs[i], bus.resp_err); end
         vectors++; if (bus.resp_instr !== 32'h0) begin miscompares++; $display("FAIL err_nop[%h]: got %h want 00000000", pcs[i], bus.resp_instr); end
      end
      bus.req_valid = 1'b0;
      step();
   endtask

   task automatic test_stall();
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_pc     = 32'h4;
      step();
      // Keep a different request pending during the stall; it must not be taken.
      bus.resp_ready = 1'b0;
      bus.req_pc     = 32'h8;
      for (int k = 0; k < 3; k++) begin
         #1;
         $display("stall cycle %0d instr=%h req_ready=%b", k, bus.resp_instr, bus.req_ready);
         vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_req_ready[%0d]: got %b want 0", k, bus.req_ready); end
         vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.resp_valid); end
         vectors++; if (bus.resp_instr !== 32'h2009_0027) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h want 20090027", k, bus.resp_instr); end
         vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL stall_err[%0d]: got %b want 0", k, bus.resp_err); end
         step();
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      #1;
      vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", bus.req_ready); end
      vectors++; if (bus.resp_instr !== 32'h2009_0027) begin miscompares++; $display("FAIL stall_release_instr: got %h want 20090027", bus.resp_instr); end
      step();
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_accept: got %b want 0", bus.resp_valid); end
      $display("stall released, resp accepted");
   endtask

   task automatic test_full_load();
      bus.load_restart = 1'b1;
      step();
      bus.load_restart = 1'b0;
      vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL full_restart_loaded: got %b want 0", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd0) begin miscompares++; $display("FAIL full_restart_count: got %0d want 0", bus.load_count); end
      for (int i = 0; i < 64; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 32'hA500_0000 + 32'(i);
         bus.load_last  = 1'b0;
         #1;
         if (i == 63) begin
            vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL full_loaded_early: got %b want 0", bus.loaded); end
            vectors++; if (bus.load_count !== 7'd63) begin miscompares++; $display("FAIL full_count63: got %0d want 63", bus.load_count); end
         end
         step();
      end
      bus.load_valid = 1'b0;
      $display("full load done loaded=%b count=%0d", bus.loaded, bus.load_count);
      vectors++; if (bus.loaded !== 1'b1) begin miscompares++; $display("FAIL full_loaded: got %b want 1", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd64) begin miscompares++; $display("FAIL full_count64: got %0d want 64", bus.load_count); end
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'hFC;
      step();
      $display("fetch pc=000000fc instr=%h err=%b", bus.resp_instr, bus.resp_err);
      vectors++; if (bus.resp_instr !== 32'hA500_003F) begin miscompares++; $display("FAIL full_word63: got %h want a500003f", bus.resp_instr); end
      vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL full_word63_err: got %b want 0", bus.resp_err); end
      bus.req_pc = 32'h0;
      step();
      vectors++; if (bus.resp_instr !== 32'hA500_0000) begin miscompares++; $display("FAIL full_word0: got %h want a5000000", bus.resp_instr); end
      bus.req_valid = 1'b0;
      step();
   endtask

   task automatic test_restart();
      bus.resp_ready   = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_pc       = 32'h0;
      bus.load_restart = 1'b1;
      step();
      bus.req_valid    = 1'b0;
      bus.load_restart = 1'b0;
      $display("restart with fetch: valid=%b loaded=%b count=%0d", bus.resp_valid, bus.loaded, bus.load_count);
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL restart_resp_valid: got %b want 0", bus.resp_valid); end
      vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL restart_loaded: got %b want 0", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd0) begin miscompares++; $display("FAIL restart_count: got %0d want 0", bus.load_count); end
      vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL restart_req_ready: got %b want 0", bus.req_ready); end
      step();
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL restart_no_resp: got %b want 0", bus.resp_valid); end
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hDEAD_BEEF;
      bus.load_last  = 1'b1;
      step();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      vectors++; if (bus.loaded !== 1'b1) begin miscompares++; $display("FAIL reload_loaded: got %b want 1", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd1) begin miscompares++; $display("FAIL reload_count: got %0d want 1", bus.load_count); end
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0;
      step();
      bus.req_valid = 1'b0;
      $display("fetch pc=00000000 instr=%h err=%b", bus.resp_instr, bus.resp_err);
      vectors++; if (bus.resp_instr !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL reload_instr: got %h want deadbeef", bus.resp_instr); end
      step();
   endtask

   task automatic test_async_reset();
      bus.load_restart = 1'b1;
      step();
      bus.load_restart = 1'b0;
      bus.load_valid   = 1'b1;
      bus.load_data    = 32'h1111_1111;
      step();
      bus.load_data    = 32'h2222_2222;
      step();
      bus.load_valid   = 1'b0;
      vectors++; if (bus.load_count !== 7'd2) begin miscompares++; $display("FAIL areset_pre_count: got %0d want 2", bus.load_count); end
      #2;
      rst = 1'b1;
      #1;
      $display("async reset mid-load: loaded=%b count=%0d", bus.loaded, bus.load_count);
      vectors++; if (bus.loaded !== 1'b0) begin miscompares++; $display("FAIL areset_loaded: got %b want 0", bus.loaded); end
      vectors++; if (bus.load_count !== 7'd0) begin miscompares++; $display("FAIL areset_count: got %0d want 0", bus.load_count); end
      vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL areset_req_ready: got %b want 0", bus.req_ready); end
      vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL areset_resp_valid: got %b want 0", bus.resp_valid); end
      vectors++; if (bus.resp_instr !== 32'h0) begin miscompares++; $display("FAIL areset_resp_instr: got %h want 00000000", bus.resp_instr); end
      vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL areset_resp_err: got %b want 0", bus.resp_err); end
      #1;
      rst = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = 32'h3333_3333;
      bus.load_last  = 1'b1;
      step();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      vectors++; if (bus.load_count !== 7'd1) begin miscompares++; $display("FAIL areset_reload_count: got %0d want 1", bus.load_count); end
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0;
      step();
      $display("fetch pc=00000000 instr=%h", bus.resp_instr);
      vectors++; if (bus.resp_instr !== 32'h3333_3333) begin miscompares++; $display("FAIL areset_word0: got %h want 33333333", bus.resp_instr); end
      bus.req_pc = 32'h4;
      step();
      $display("fetch pc=00000004 instr=%h", bus.resp_instr);
      vectors++; if (bus.resp_instr !== 32'h2222_2222) begin miscompares++; $display("FAIL areset_word1_kept: got %h want 22222222", bus.resp_instr); end
      bus.req_valid = 1'b0;
      step();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_load_fetch();
      test_errors();
      test_stall();
      test_full_load();
      test_restart();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
